// File: rtl/cmp2bit_reg.sv
// Registered 2-bit unsigned magnitude comparator slice with saturating result counters.
// Optional cascade inputs from a less-significant slice are enabled with CMP_CASCADE_EN.
module cmp2bit_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

module cmp2bit_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             cnt_clr,
`ifdef CMP_CASCADE_EN
  input  logic             casc_eq_in,
  input  logic             casc_gt_in,
  input  logic             casc_lt_in,
`endif
  output logic             out_valid,
  output logic             equal,
  output logic             more,
  output logic             less,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
);
  logic ceq, cgt, clt;
`ifdef CMP_CASCADE_EN
  assign ceq = casc_eq_in;
  assign cgt = casc_gt_in;
  assign clt = casc_lt_in;
`else
  // A standalone slice behaves like the least-significant one: lower bits "equal".
  assign ceq = 1'b1;
  assign cgt = 1'b0;
  assign clt = 1'b0;
`endif

  logic hi_eq, eq_c, gt_c, lt_c;
  assign hi_eq = a[1] ~^ b[1];
  assign eq_c  = hi_eq & (a[0] ~^ b[0]);
  assign gt_c  = (a[1] & ~b[1]) | (hi_eq & a[0] & ~b[0]);
  assign lt_c  = ~eq_c & ~gt_c;

  // res[0]=equal, res[1]=more, res[2]=less
  logic [2:0] res;
  assign res[0] = eq_c & ceq;
  assign res[1] = gt_c | (eq_c & cgt);
  assign res[2] = lt_c | (eq_c & clt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      equal     <= 1'b0;
      more      <= 1'b0;
      less      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        equal <= res[0];
        more  <= res[1];
        less  <= res[2];
      end
    end
  end

  logic [2:0][CNT_W-1:0] cnt;
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    cmp2bit_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .inc  (in_valid & res[i]),
      .cnt  (cnt[i])
    );
  end

  assign cnt_eq = cnt[0];
  assign cnt_gt = cnt[1];
  assign cnt_lt = cnt[2];
endmodule

// File: tb/tb_cmp2bit_reg.sv
// Directed bench for cmp2bit_reg: a CNT_W=8 instance and a CNT_W=2 instance share stimulus.
module tb_cmp2bit_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] a = '0, b = '0;
  logic       cnt_clr = 1'b0;
`ifdef CMP_CASCADE_EN
  logic       casc_eq_in = 1'b1, casc_gt_in = 1'b0, casc_lt_in = 1'b0;
`endif
  logic       out_valid, equal, more, less;
  logic [7:0] cnt_eq, cnt_gt, cnt_lt;
  logic       s_out_valid, s_equal, s_more, s_less;
  logic [1:0] s_cnt_eq, s_cnt_gt, s_cnt_lt;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  cmp2bit_reg #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
`ifdef CMP_CASCADE_EN
    .casc_eq_in(casc_eq_in), .casc_gt_in(casc_gt_in), .casc_lt_in(casc_lt_in),
`endif
    .out_valid(out_valid), .equal(equal), .more(more), .less(less),
    .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt)
  );

  cmp2bit_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
`ifdef CMP_CASCADE_EN
    .casc_eq_in(casc_eq_in), .casc_gt_in(casc_gt_in), .casc_lt_in(casc_lt_in),
`endif
    .out_valid(s_out_valid), .equal(s_equal), .more(s_more), .less(s_less),
    .cnt_eq(s_cnt_eq), .cnt_gt(s_cnt_gt), .cnt_lt(s_cnt_lt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // drive one cycle's inputs, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic [1:0] av, input logic [1:0] bv, input logic clr);
    in_valid = v; a = av; b = bv; cnt_clr = clr;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] flags();
    return {out_valid, equal, more, less};
  endfunction

  initial begin
    logic [3:0] exp;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_flags", 32'(flags()), 32'h0);
    chk("reset_cnts", {cnt_eq, cnt_gt, cnt_lt}, 32'h0);

    // hand-checked examples
    step(1, 2'd2, 2'd1, 0); chk("ex_2gt1", 32'(flags()), 32'b1010);
    step(1, 2'd1, 2'd3, 0); chk("ex_1lt3", 32'(flags()), 32'b1001);
    step(1, 2'd3, 2'd3, 0); chk("ex_3eq3", 32'(flags()), 32'b1100);
    step(1, 2'd0, 2'd0, 1);
    chk("clr_with_valid_cnt", {cnt_eq, cnt_gt, cnt_lt}, 32'h0);
    chk("clr_with_valid_flags", 32'(flags()), 32'b1100);

    // exhaustive sweep
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        step(1, 2'(i), 2'(j), 0);
        exp = (i == j) ? 4'b1100 : (i > j) ? 4'b1010 : 4'b1001;
        chk($sformatf("sweep_a%0d_b%0d", i, j), 32'(flags()), 32'(exp));
      end
    chk("sweep_cnts", {cnt_eq, cnt_gt, cnt_lt}, {8'd4, 8'd6, 8'd6});
    chk("sweep_sat_cnts", {s_cnt_eq, s_cnt_gt, s_cnt_lt}, {2'd3, 2'd3, 2'd3});

    // hold while in_valid low
    step(1, 2'd0, 2'd2, 0); chk("hold_load", 32'(flags()), 32'b1001);
    step(0, 2'd3, 2'd0, 0); chk("hold_1", 32'(flags()), 32'b0001);
    step(0, 2'd2, 2'd2, 0); chk("hold_2", 32'(flags()), 32'b0001);
    chk("hold_cnts", {cnt_eq, cnt_gt, cnt_lt}, {8'd4, 8'd6, 8'd7});

    // clear together with a valid sample
    step(1, 2'd3, 2'd1, 1);
    chk("clr_v_cnts", {cnt_eq, cnt_gt, cnt_lt}, 32'h0);
    chk("clr_v_sat", {s_cnt_eq, s_cnt_gt, s_cnt_lt}, 32'h0);
    chk("clr_v_flags", 32'(flags()), 32'b1010);

    // saturation on the CNT_W=2 instance
    for (int k = 0; k < 6; k++) step(1, 2'd1, 2'd1, 0);
    chk("sat_cnt_eq", 32'(s_cnt_eq), 32'd3);
    chk("sat_flags", {s_out_valid, s_equal, s_more, s_less}, 32'b1100);
    chk("nosat_cnt_eq", 32'(cnt_eq), 32'd6);

    // mid-cycle asynchronous reset with a result pending
    in_valid = 1'b1; a = 2'd3; b = 2'd0;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("async_rst_flags", 32'(flags()), 32'h0);
    chk("async_rst_cnts", {cnt_eq, cnt_gt, cnt_lt}, 32'h0);
    chk("async_rst_sat", {s_cnt_eq, s_cnt_gt, s_cnt_lt}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(flags()), 32'h0);
    step(1, 2'd0, 2'd1, 0); chk("post_rst_first", 32'(flags()), 32'b1001);
    chk("post_rst_cnts", {cnt_eq, cnt_gt, cnt_lt}, {8'd0, 8'd0, 8'd1});

`ifdef CMP_CASCADE_EN
    casc_eq_in = 0; casc_gt_in = 1; casc_lt_in = 0;
    step(1, 2'd2, 2'd2, 0); chk("casc_eq_gt", 32'(flags()), 32'b1010);
    casc_eq_in = 0; casc_gt_in = 0; casc_lt_in = 1;
    step(1, 2'd1, 2'd0, 0); chk("casc_hi_gt", 32'(flags()), 32'b1010);
    step(1, 2'd1, 2'd1, 0); chk("casc_eq_lt", 32'(flags()), 32'b1001);
    casc_eq_in = 1; casc_gt_in = 0; casc_lt_in = 0;
    step(1, 2'd1, 2'd1, 0); chk("casc_eq_eq", 32'(flags()), 32'b1100);
    chk("casc_cnts", {cnt_eq, cnt_gt, cnt_lt}, {8'd1, 8'd2, 8'd2});
`endif

    in_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
